// File: rtl/btn_conditioner_if.sv
// Board-side input bundle for the calculator front end: raw buttons and switches in,
// conditioned levels, press pulses and synchronized switches out.
interface btn_conditioner_if #(
    parameter int N_BTN = 5,
    parameter int SW_W  = 16
);
    logic [N_BTN-1:0] btn_raw;
    logic [SW_W-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [SW_W-1:0]  sw_sync;

    // master: the board / stimulus side
    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_pulse,
        input  sw_sync
    );

    // slave: the conditioner itself
    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_pulse,
        output sw_sync
    );
endinterface

// File: rtl/btn_conditioner.sv
// Pushbutton/switch front end: 2-flop synchronizers, per-button debounce with a
// stable-count qualifier, and a registered one-cycle pulse on each accepted press.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_W            = 16,
    parameter int CNT_W           = 20
) (
    input logic              clk,
    input logic              reset,
    btn_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] btn_s1_reg;
    logic [N_BTN-1:0] btn_s2_reg;
    logic [SW_W-1:0]  sw_s1_reg;
    logic [SW_W-1:0]  sw_s2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_reg <= '0;
            btn_s2_reg <= '0;
            sw_s1_reg  <= '0;
            sw_s2_reg  <= '0;
        end else begin
            btn_s1_reg <= bus.btn_raw;
            btn_s2_reg <= btn_s1_reg;
            sw_s1_reg  <= bus.sw_raw;
            sw_s2_reg  <= sw_s1_reg;
        end
    end

    assign bus.sw_sync = sw_s2_reg;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             stable_reg;
            logic             stable_next;
            logic             pulse_reg;
            logic             pulse_next;

            // Any cycle where the synchronized input matches the accepted level
            // restarts the count, so only an unbroken run of differing cycles wins.
            always_comb begin
                cnt_next    = '0;
                stable_next = stable_reg;
                pulse_next  = 1'b0;
                if (btn_s2_reg[gi] != stable_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        stable_next = btn_s2_reg[gi];
                        pulse_next  = btn_s2_reg[gi];
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                    pulse_reg  <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= stable_next;
                    pulse_reg  <= pulse_next;
                end
            end

            assign bus.btn_level[gi] = stable_reg;
            assign bus.btn_pulse[gi] = pulse_reg;
        end
    endgenerate
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4 (raw edge to level = 6 cycles).
module tb_btn_conditioner;
    localparam int N_BTN = 5;
    localparam int SW_W  = 16;
    localparam int DEB   = 4;
    localparam int LAT   = 2 + DEB;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    btn_conditioner_if #(.N_BTN(N_BTN), .SW_W(SW_W)) bus ();

    btn_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .SW_W           (SW_W),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.btn_raw = 5'h1F;
        bus.sw_raw  = 16'hFFFF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (bus.btn_level !== 5'h00 || bus.btn_pulse !== 5'h00 || bus.sw_sync !== 16'h0000)
                $display("FAIL reset_hold cyc%0d: level=%h pulse=%h sw=%h, required 0/0/0",
                         c, bus.btn_level, bus.btn_pulse, bus.sw_sync);
            else passed++;
        end
        reset       = 1'b0;
        bus.btn_raw = 5'h00;
        bus.sw_raw  = 16'h0000;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (bus.btn_level !== 5'h00 || bus.btn_pulse !== 5'h00 || bus.sw_sync !== 16'h0000)
            $display("FAIL reset_idle: level=%h pulse=%h sw=%h, required 0/0/0",
                     bus.btn_level, bus.btn_pulse, bus.sw_sync);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        bus.btn_raw[4] = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            checks++;
            if (bus.btn_level[4] !== (c >= LAT) || bus.btn_pulse[4] !== (c == LAT))
                $display("FAIL clean_press cyc%0d: level4=%b pulse4=%b, required %b/%b",
                         c, bus.btn_level[4], bus.btn_pulse[4], c >= LAT, c == LAT);
            else passed++;
        end
        $display("test_clean_press done");
    endtask

    task automatic test_bounce();
        logic [3:0] pattern;
        int         pulses;
        pattern = 4'b1010;
        pulses  = 0;
        for (int b = 3; b >= 0; b--) begin
            bus.btn_raw[1] = pattern[b];
            tick();
            pulses += int'(bus.btn_pulse[1]);
            checks++;
            if (bus.btn_level[1] !== 1'b0)
                $display("FAIL bounce_hold step%0d: level1=%b, required 0", 3 - b, bus.btn_level[1]);
            else passed++;
        end
        bus.btn_raw[1] = 1'b1;
        for (int c = 1; c <= LAT + 3; c++) begin
            tick();
            pulses += int'(bus.btn_pulse[1]);
            checks++;
            if (bus.btn_level[1] !== (c >= LAT) || bus.btn_pulse[1] !== (c == LAT))
                $display("FAIL bounce_settle cyc%0d: level1=%b pulse1=%b, required %b/%b",
                         c, bus.btn_level[1], bus.btn_pulse[1], c >= LAT, c == LAT);
            else passed++;
        end
        checks++;
        if (pulses !== 1)
            $display("FAIL bounce_pulse_count: got %0d, required 1", pulses);
        else passed++;
        $display("test_bounce done");
    endtask

    task automatic test_hold_release();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            pulses += int'(bus.btn_pulse[4]);
        end
        checks++;
        if (pulses !== 0 || bus.btn_level[4] !== 1'b1)
            $display("FAIL hold_no_repeat: pulses=%0d level4=%b, required 0/1", pulses, bus.btn_level[4]);
        else passed++;
        bus.btn_raw[4] = 1'b0;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            checks++;
            if (bus.btn_level[4] !== (c < LAT) || bus.btn_pulse[4] !== 1'b0)
                $display("FAIL release cyc%0d: level4=%b pulse4=%b, required %b/0",
                         c, bus.btn_level[4], bus.btn_pulse[4], c < LAT);
            else passed++;
        end
        $display("test_hold_release done");
    endtask

    task automatic test_simultaneous();
        logic [4:0] mask;
        mask = 5'b01001;
        bus.btn_raw[0] = 1'b1;
        bus.btn_raw[3] = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            tick();
            checks++;
            if ((bus.btn_level & mask) !== (c >= LAT ? mask : 5'b0) ||
                (bus.btn_pulse & mask) !== (c == LAT ? mask : 5'b0))
                $display("FAIL simultaneous cyc%0d: level=%b pulse=%b, required %b/%b", c,
                         bus.btn_level & mask, bus.btn_pulse & mask,
                         c >= LAT ? mask : 5'b0, c == LAT ? mask : 5'b0);
            else passed++;
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_switches();
        bus.sw_raw = 16'hA5C3;
        tick();
        checks++;
        if (bus.sw_sync !== 16'h0000)
            $display("FAIL sw_latency1: sw=%h, required 0000", bus.sw_sync);
        else passed++;
        tick();
        checks++;
        if (bus.sw_sync !== 16'hA5C3)
            $display("FAIL sw_latency2: sw=%h, required a5c3", bus.sw_sync);
        else passed++;
        $display("test_switches done");
    endtask

    task automatic test_reset_mid_debounce();
        bus.btn_raw = 5'h00;
        for (int c = 0; c < LAT + 2; c++) tick();
        checks++;
        if (bus.btn_level !== 5'h00)
            $display("FAIL release_all: level=%h, required 00", bus.btn_level);
        else passed++;
        bus.btn_raw[4] = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.btn_level !== 5'h00 || bus.btn_pulse !== 5'h00 || bus.sw_sync !== 16'h0000)
            $display("FAIL mid_reset: level=%h pulse=%h sw=%h, required 0/0/0",
                     bus.btn_level, bus.btn_pulse, bus.sw_sync);
        else passed++;
        reset = 1'b0;
        // Button still held: a full fresh debounce must run from scratch.
        for (int c = 1; c <= LAT; c++) begin
            tick();
            checks++;
            if (bus.btn_level[4] !== (c >= LAT) || bus.btn_pulse[4] !== (c == LAT))
                $display("FAIL after_reset cyc%0d: level4=%b pulse4=%b, required %b/%b",
                         c, bus.btn_level[4], bus.btn_pulse[4], c >= LAT, c == LAT);
            else passed++;
        end
        $display("test_reset_mid_debounce done");
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        reset       = 1'b1;
        bus.btn_raw = '0;
        bus.sw_raw  = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_release();
        test_simultaneous();
        test_switches();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
